// File: rtl/log2_pkg.sv
// Shared types and constants for the fixed-point log2 block.
package log2_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned INT_W         = 5;
  localparam int unsigned FRAC_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/Log2_32.sv
// Combinational floor(log2(A)) for a 32-bit operand; returns 0 for A==0.
module Log2_32
  import log2_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  output logic [INT_W-1:0]  log2
);

  // Priority encode: the highest set bit wins because later iterations overwrite.
  always_comb begin
    log2 = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (A[i]) log2 = INT_W'(i);
    end
  end

endmodule

// File: rtl/log2_frac_32.sv
// Iterative fixed-point log2 of a 32-bit unsigned operand.
// Result is {int[4:0], frac[FRAC_BITS-1:0]}; fraction bits are produced MSB
// first by repeated squaring of the normalised mantissa.
// Optional build macro LOG2_ROUND_EN: one extra guard iteration and
// round-half-up (saturating) instead of truncation.
module log2_frac_32
  import log2_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF  // legal range 1..16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_W-1:0]          A,
  output logic                       busy,
  output logic                       done,
  output logic [INT_W+FRAC_BITS-1:0] result,
  output logic                       zero_err
);

`ifdef LOG2_ROUND_EN
  localparam int unsigned ITERS = FRAC_BITS + 1;
`else
  localparam int unsigned ITERS = FRAC_BITS;
`endif
  localparam int unsigned RES_W = INT_W + FRAC_BITS;
  localparam logic [4:0]  LAST  = 5'(ITERS - 1);

  state_t              state;
  logic [DATA_W-1:0]   a_q;
  logic [INT_W-1:0]    k_q;
  logic [INT_W-1:0]    k;
  logic [DATA_W-1:0]   m;
  logic [4:0]          cnt;
  logic [ITERS-1:0]    acc;

  logic [2*DATA_W-1:0] p;
  logic                frac_bit;
  logic [DATA_W-1:0]   m_next;
  logic [ITERS-1:0]    acc_next;
  logic [RES_W-1:0]    res_final;
  logic                unused_p_lo;

  Log2_32 u_log2 (
    .A    (A),
    .log2 (k)
  );

  // One squaring step: p = m*m in Q2.62, renormalise back to Q1.31.
  always_comb begin
    p         = {32'b0, m} * {32'b0, m};
    frac_bit  = p[63];
    m_next    = p[63] ? p[63:32] : p[62:31];
    acc_next  = (acc << 1) | ITERS'(frac_bit);
`ifdef LOG2_ROUND_EN
    // Lowest accumulated bit is the guard; all-ones cannot round up and saturates.
    res_final = {k_q, acc_next[ITERS-1:1]};
    if (acc_next[0] && (res_final != '1)) res_final = res_final + RES_W'(1);
`else
    res_final = {k_q, acc_next};
`endif
  end

  assign unused_p_lo = ^p[30:0];

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      k_q      <= '0;
      m        <= '0;
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (A != '0) begin
              a_q   <= A;
              k_q   <= k;
              state <= NORM;
            end else begin
              result   <= '0;
              zero_err <= 1'b1;
              state    <= DONE;
            end
          end
        end
        NORM: begin
          m     <= a_q << (5'd31 - k_q);
          cnt   <= '0;
          acc   <= '0;
          state <= ITER;
        end
        ITER: begin
          m   <= m_next;
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            result   <= res_final;
            zero_err <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          // done is registered here so it appears the cycle after DONE.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_frac_32.sv
// Directed, table-driven bench for log2_frac_32 (FRAC_BITS=8).
module tb_log2_frac_32;

  localparam int FB = 8;
  localparam int RW = 5 + FB;
`ifdef LOG2_ROUND_EN
  localparam int LAT = FB + 3;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = FB + 2;
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   A;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          zero_err;

  int n_cmp = 0;
  int n_bad = 0;

  log2_frac_32 #(.FRAC_BITS(FB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero_err (zero_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   a;
    logic [RW-1:0] r_trunc;
    logic [RW-1:0] r_round;
    bit            z;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one start, wait for done, check latency, result, flags and pulse width.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [RW-1:0] exp_r,
                        input bit exp_z, input int exp_lat);
    int lat;
    bit busy_ok;
    lat     = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    A     = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, 32'(result), 32'(exp_r));
    check({tag, " zero_err"}, 32'(zero_err), 32'(exp_z));
    check({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
    check({tag, " busy_while_running"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " result_held"}, 32'(result), 32'(exp_r));
  endtask

  initial begin
    int lat;
    int lat2;
    int dones;

    vt[0] = '{32'd1,          13'h0000, 13'h0000, 1'b0};
    vt[1] = '{32'd3,          13'h0195, 13'h0196, 1'b0};
    vt[2] = '{32'd5,          13'h0252, 13'h0252, 1'b0};
    vt[3] = '{32'd7,          13'h02CE, 13'h02CF, 1'b0};
    vt[4] = '{32'd1000,       13'h09F7, 13'h09F7, 1'b0};
    vt[5] = '{32'h8000_0000,  13'h1F00, 13'h1F00, 1'b0};
    vt[6] = '{32'hFFFF_FFFF,  13'h1FFF, 13'h1FFF, 1'b0};
    vt[7] = '{32'd0,          13'h0000, 13'h0000, 1'b1};
    vt[8] = '{32'd8,          13'h0300, 13'h0300, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset zero_err", 32'(zero_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].a, RND ? vt[i].r_round : vt[i].r_trunc,
             vt[i].z, vt[i].z ? 1 : LAT);
    end

    // Start during ITER (cycle 4) must be ignored.
    @(negedge clk);
    A     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) begin
        start = 1'b1;
        A     = 32'd8;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    check("midrun_start latency", lat, LAT);
    check("midrun_start result", 32'(result), RND ? 32'h0196 : 32'h0195);
    repeat (3) @(posedge clk);
    #1;
    check("midrun_start no_restart", 32'(busy), 32'd0);

    // Start held from the DONE cycle: ignored there, accepted in the following IDLE cycle.
    @(negedge clk);
    A     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    lat2  = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (c >= LAT - 1 && c <= LAT) begin
        start = 1'b1;
        A     = 32'd8;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        if (lat < 0) begin
          lat = c;
          check("b2b first result", 32'(result), RND ? 32'h0196 : 32'h0195);
        end else begin
          lat2 = c;
          break;
        end
      end
    end
    check("b2b first latency", lat, LAT);
    check("b2b second latency", lat2, 2 * LAT + 1);
    check("b2b second result", 32'(result), 32'h0300);

    // Reset mid-operation: everything clears, no done follows.
    @(negedge clk);
    A     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrun_reset busy", 32'(busy), 32'd0);
    check("midrun_reset done", 32'(done), 32'd0);
    check("midrun_reset result", 32'(result), 32'd0);
    check("midrun_reset zero_err", 32'(zero_err), 32'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check("midrun_reset no_done", dones, 0);

    // Normal operation resumes after the interrupted run.
    run_op("after_reset", 32'd8, 13'h0300, 1'b0, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/log2_frac_32.md
LOG2_FRAC_32 -- requirements
Module: log2_frac_32

Interface
REQ-001 Parameter FRAC_BITS, default 8, sets the number of fractional result bits; the legal range is 1..16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  32  unsigned operand; sampled with start.
REQ-006 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-007 done  output  1  one-cycle pulse marking a valid result.
REQ-008 result  output  5+FRAC_BITS  unsigned fixed-point log2(A) as {int[4:0], frac[FRAC_BITS-1:0]}; held until the next accepted start.
REQ-009 zero_err  output  1  set when A==0; held with result.

Function
REQ-010 The FSM SHALL have states IDLE, NORM, ITER and DONE.
REQ-011 IDLE with start=1 and A!=0 SHALL latch A and the integer part k=floor(log2 A), then go to NORM.
REQ-012 IDLE with start=1 and A==0 SHALL go to DONE with result=0 and zero_err=1.
REQ-013 NORM SHALL load mantissa m = A<<(31-k) as Q1.31 (1<=m<2), store int=k, clear the iteration counter, and go to ITER.
REQ-014 Each ITER cycle SHALL form the full 64-bit product p=m*m (Q2.62).
REQ-015 If p[63]=1 in ITER, the next fractional bit SHALL be 1 and m SHALL become p[63:32].
REQ-016 If p[63]=0 in ITER, the next fractional bit SHALL be 0 and m SHALL become p[62:31].
REQ-017 Fractional bits SHALL be produced MSB first, one per ITER cycle.
REQ-018 After FRAC_BITS ITER cycles the FSM SHALL go to DONE.
REQ-019 Without rounding, the fraction SHALL be truncated.
REQ-020 DONE SHALL assert done for exactly one cycle, drive busy low, and return to IDLE.
REQ-021 For A!=0, done SHALL rise FRAC_BITS+2 cycles after the start-sampling edge (FRAC_BITS=8: 10 cycles).
REQ-022 For A==0, done SHALL rise 1 cycle after the start-sampling edge.
REQ-023 start outside IDLE SHALL be ignored; A is don't-care except in the cycle start is accepted.
REQ-024 A back-to-back start asserted in the DONE cycle SHALL be ignored; the earliest accepted restart is the IDLE cycle that follows.
REQ-025 result and zero_err SHALL change only on DONE entry or reset.

Reset
REQ-026 reset SHALL force IDLE on the next edge, including mid-operation.
REQ-027 reset SHALL clear busy, done, result, zero_err, m and the counter to 0.
REQ-028 An operation interrupted by reset SHALL produce no done.

Configuration
REQ-029 With LOG2_ROUND_EN defined, the block SHALL run one extra ITER cycle for a guard bit and round half-up; done latency becomes FRAC_BITS+3.
REQ-030 With LOG2_ROUND_EN defined, a rounding carry SHALL propagate into int; if {int, frac} is already all ones, the result SHALL saturate to all ones.
REQ-031 Without LOG2_ROUND_EN, the block SHALL truncate as in REQ-019 with the latency of REQ-021.

Structure
REQ-032 Package log2_pkg SHALL hold the state enum, DATA_W=32, INT_W=5 and FRAC_BITS_DEF=8.
REQ-033 The integer part k SHALL come from one instance of the existing combinational Log2_32 (ports A, log2), driven by the operand input; no priority encoder is duplicated.

Verification
REQ-034 With FRAC_BITS=8, A=1, start -> result 13'h0000, zero_err=0, done at cycle 10.
REQ-035 A=3 -> 13'h0195 (1.58203) truncated; with LOG2_ROUND_EN -> 13'h0196, done at cycle 11.
REQ-036 A=32'h80000000 -> 13'h1F00; A=32'hFFFFFFFF -> 13'h1FFF, with and without LOG2_ROUND_EN (saturation).
REQ-037 A=0, start -> done next cycle, result 0, zero_err=1; a following A=8 -> 13'h0300, zero_err=0.
REQ-038 Start A=3, then start with A=8 at cycle 4 -> ignored, result 13'h0195.
REQ-039 Start A=3, reset at cycle 5 -> busy=0 and all outputs 0 next cycle, no done.
